// File: rtl/nes_oam_dma.sv
// nes_oam_dma: owns the CPU memory bus and sequences OAM sprite DMA.
// In IDLE the CPU bus passes straight through to memory. A CPU write to
// DMA_PORT stalls the CPU and copies page {page,00..FF} to OAM_PORT as
// alternating read/write cycles, then returns the bus to the CPU.
module nes_oam_dma #(
  parameter logic [15:0] DMA_PORT = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004,
  parameter bit          ALIGN_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_rd,
  input  logic        cpu_we,
  output logic        cpu_ready,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic [7:0]  mem_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  page_reg, page_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  latch_reg, latch_next;
  logic        odd_reg;

  // Trigger is write-only; reads of the DMA port are ordinary reads.
  logic trigger;
  assign trigger = cpu_we && (cpu_address == DMA_PORT);

  // Alignment is only ever needed when enabled and the halt lands on an odd cycle.
  logic need_align;
  assign need_align = ALIGN_EN && odd_reg;

  // State and datapath registers; odd toggles every clock to track bus parity.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      page_reg  <= 8'h00;
      idx_reg   <= 8'h00;
      latch_reg <= 8'h00;
      odd_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
      latch_reg <= latch_next;
      odd_reg   <= ~odd_reg;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    latch_next = latch_reg;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          page_next  = cpu_out;
          idx_next   = 8'h00;
          state_next = HALT;
        end
      end
      HALT: begin
        state_next = need_align ? ALIGN : READ;
      end
      ALIGN: begin
        state_next = READ;
      end
      READ: begin
        latch_next = mem_data;
        state_next = WRITE;
      end
      WRITE: begin
        idx_next   = idx_reg + 8'h01;
        state_next = (idx_reg == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus outputs decoded directly from the current state, no output latency.
  always_comb begin
    cpu_ready   = 1'b1;
    mem_address = cpu_address;
    mem_out     = cpu_out;
    mem_rd      = cpu_rd;
    mem_we      = cpu_we;
    case (state_reg)
      IDLE: begin
        cpu_ready = 1'b1;
      end
      HALT, ALIGN: begin
        cpu_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
      end
      READ: begin
        cpu_ready   = 1'b0;
        mem_address = {page_reg, idx_reg};
        mem_rd      = 1'b1;
        mem_we      = 1'b0;
      end
      WRITE: begin
        cpu_ready   = 1'b0;
        mem_address = OAM_PORT;
        mem_out     = latch_reg;
        mem_rd      = 1'b0;
        mem_we      = 1'b1;
      end
      default: begin
        cpu_ready = 1'b1;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_nes_oam_dma.sv
// Testbench for nes_oam_dma: drives CPU traffic and DMA triggers, models
// memory as a byte array, and checks bus ownership, stall length and the
// copied byte stream against a reference derived from the page contents.
module tb_nes_oam_dma;

  localparam logic [15:0] DMA_PORT = 16'h4014;
  localparam logic [15:0] OAM_PORT = 16'h2004;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_address = 16'h0000;
  logic [7:0]  cpu_out = 8'h00;
  logic        cpu_rd = 1'b0;
  logic        cpu_we = 1'b0;

  logic        cpu_ready, mem_rd, mem_we, busy;
  logic [15:0] mem_address;
  logic [7:0]  mem_out, mem_data;

  logic        cpu_ready1, mem_rd1, mem_we1, busy1;
  logic [15:0] mem_address1;
  logic [7:0]  mem_out1, mem_data1;

  logic [7:0]  mem_arr [0:65535];

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc = 0;

  // Monitor state (written only by the monitor process)
  int          halted_cnt = 0;
  int          halted1_cnt = 0;
  int          gap_cnt = 0;
  int          oam_cnt = 0;
  int          wr1_cnt = 0;
  logic [7:0]  wr1_xor = 8'h00;
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  logic [15:0] wr_addr_q[$];

  nes_oam_dma #(.DMA_PORT(DMA_PORT), .OAM_PORT(OAM_PORT), .ALIGN_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
    .cpu_ready(cpu_ready), .mem_address(mem_address), .mem_out(mem_out),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data), .busy(busy)
  );

  nes_oam_dma #(.DMA_PORT(DMA_PORT), .OAM_PORT(OAM_PORT), .ALIGN_EN(1'b0)) dut_noalign (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
    .cpu_ready(cpu_ready1), .mem_address(mem_address1), .mem_out(mem_out1),
    .mem_rd(mem_rd1), .mem_we(mem_we1), .mem_data(mem_data1), .busy(busy1)
  );

  assign mem_data  = mem_arr[mem_address];
  assign mem_data1 = mem_arr[mem_address1];

  always #5 clock = ~clock;

  // Cycle counter whose parity equals the spec's odd flop (0 in the first cycle after reset)
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Bus monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!cpu_ready)  halted_cnt++;
    if (!cpu_ready1) halted1_cnt++;
    if (busy && mem_rd) rd_q.push_back(mem_address);
    if (busy && mem_we) begin
      wr_q.push_back(mem_out);
      wr_addr_q.push_back(mem_address);
    end
    if (busy && !mem_rd && !mem_we) gap_cnt++;
    if (mem_we && mem_address == OAM_PORT) oam_cnt++;
    if (busy1 && mem_we1 && mem_address1 == OAM_PORT) begin
      wr1_cnt++;
      wr1_xor = wr1_xor ^ mem_out1;
    end
    if (busy1 && mem_rd1 && mem_address1[15:8] == 8'hFF && mem_address1[7:0] == 8'h00) gap_cnt = gap_cnt + 0;
  end

  // Random CPU address that can never trigger a DMA or hit the OAM port
  function automatic logic [15:0] safe_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == DMA_PORT || a == OAM_PORT) a = 16'h1000;
    return a;
  endfunction

  // Trigger a DMA so the HALT cycle lands on the requested parity, then wait for completion
  task automatic run_dma(input logic [7:0] pg, input bit want_odd, input bit retrig,
                         output bit timed_out);
    @(posedge clock); #1;
    if (((cyc + 1) % 2) != int'(want_odd)) begin
      @(posedge clock); #1;
    end
    cpu_address = DMA_PORT; cpu_out = pg; cpu_we = 1'b1; cpu_rd = 1'b0;
    @(posedge clock); #1;
    if (retrig) begin
      cpu_out = 8'h07;
    end else begin
      cpu_we = 1'b0; cpu_address = 16'($urandom); cpu_out = 8'($urandom);
    end
    timed_out = 1'b1;
    for (int n = 0; n < 700; n++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_address = safe_addr(); cpu_out = 8'($urandom);
      cpu_rd = 1'($urandom); cpu_we = 1'b0;
      #1;
      check_cnt++;
      if (cpu_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle: ready=%b busy=%b expected 1/0", cpu_ready, busy);
      else pass_cnt++;
      check_cnt++;
      if (mem_address !== cpu_address || mem_out !== cpu_out || mem_rd !== cpu_rd || mem_we !== cpu_we)
        $display("FAIL reset_mirror: mem=%h/%h/%b/%b expected %h/%h/%b/%b",
                 mem_address, mem_out, mem_rd, mem_we, cpu_address, cpu_out, cpu_rd, cpu_we);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    cpu_address = 16'h1234; cpu_out = 8'h5A; cpu_we = 1'b1; cpu_rd = 1'b0;
    #1;
    check_cnt++;
    if (mem_address !== 16'h1234 || mem_out !== 8'h5A || mem_we !== 1'b1 || cpu_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL passthrough_1234: mem=%h/%h we=%b ready=%b busy=%b expected 1234/5a 1 1 0",
               mem_address, mem_out, mem_we, cpu_ready, busy);
    else pass_cnt++;
    @(posedge clock); #1;
    // Read of the DMA port must not trigger
    cpu_we = 1'b0; cpu_rd = 1'b1; cpu_address = DMA_PORT; cpu_out = 8'h33;
    #1;
    check_cnt++;
    if (mem_rd !== 1'b1 || mem_address !== DMA_PORT) $display("FAIL rd_dma_port_pass: rd=%b addr=%h expected 1/4014", mem_rd, mem_address);
    else pass_cnt++;
    @(posedge clock); #1;
    cpu_rd = 1'b0;
    #1;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL rd_no_trigger: busy=%b expected 0", busy);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      cpu_address = safe_addr(); cpu_out = 8'($urandom);
      cpu_rd = 1'($urandom); cpu_we = 1'($urandom);
      #1;
      check_cnt++;
      if (mem_address !== cpu_address || mem_out !== cpu_out || mem_rd !== cpu_rd || mem_we !== cpu_we || cpu_ready !== 1'b1)
        $display("FAIL passthrough_rand: mem=%h/%h/%b/%b ready=%b expected %h/%h/%b/%b 1",
                 mem_address, mem_out, mem_rd, mem_we, cpu_ready, cpu_address, cpu_out, cpu_rd, cpu_we);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    cpu_we = 1'b0; cpu_rd = 1'b0;
    $display("test_passthrough done");
  endtask

  task automatic test_dma_even();
    int h0, h1, g0, rb, wb, bad_rd, bad_wr;
    bit to;
    for (int i = 0; i < 256; i++) mem_arr[16'h0200 + i] = 8'(i) ^ 8'hA5;
    h0 = halted_cnt; h1 = halted1_cnt; g0 = gap_cnt; rb = rd_q.size(); wb = wr_q.size();
    run_dma(8'h02, 1'b0, 1'b0, to);
    check_cnt++;
    if (to) $display("FAIL even_timeout: busy=%b expected 0 within budget", busy);
    else pass_cnt++;
    check_cnt++;
    if (halted_cnt - h0 != 513) $display("FAIL even_halted: got %0d expected 513", halted_cnt - h0);
    else pass_cnt++;
    check_cnt++;
    if (halted1_cnt - h1 != 513) $display("FAIL even_halted_noalign: got %0d expected 513", halted1_cnt - h1);
    else pass_cnt++;
    check_cnt++;
    if (gap_cnt - g0 != 1) $display("FAIL even_gap_cycles: got %0d expected 1", gap_cnt - g0);
    else pass_cnt++;
    check_cnt++;
    if (rd_q.size() - rb != 256 || wr_q.size() - wb != 256)
      $display("FAIL even_counts: reads=%0d writes=%0d expected 256/256", rd_q.size() - rb, wr_q.size() - wb);
    else begin
      pass_cnt++;
      bad_rd = 0; bad_wr = 0;
      for (int i = 0; i < 256; i++) begin
        if (rd_q[rb + i] !== 16'h0200 + 16'(i)) bad_rd++;
        if (wr_q[wb + i] !== (8'(i) ^ 8'hA5) || wr_addr_q[wb + i] !== OAM_PORT) bad_wr++;
      end
      check_cnt++;
      if (bad_rd != 0) $display("FAIL even_read_addrs: %0d wrong, first=%h expected 0200", bad_rd, rd_q[rb]);
      else pass_cnt++;
      check_cnt++;
      if (bad_wr != 0) $display("FAIL even_write_data: %0d wrong, first=%h expected a5", bad_wr, wr_q[wb]);
      else pass_cnt++;
    end
    $display("test_dma_even done");
  endtask

  task automatic test_dma_odd();
    int h0, h1, g0, rb, wb, w1b, bad;
    logic [7:0] pg, x0, exp_xor;
    bit to;
    pg = 8'($urandom_range(3, 254));
    h0 = halted_cnt; h1 = halted1_cnt; g0 = gap_cnt; rb = rd_q.size(); wb = wr_q.size();
    w1b = wr1_cnt; x0 = wr1_xor;
    run_dma(pg, 1'b1, 1'b0, to);
    check_cnt++;
    if (to) $display("FAIL odd_timeout: busy=%b expected 0 within budget", busy);
    else pass_cnt++;
    check_cnt++;
    if (halted_cnt - h0 != 514) $display("FAIL odd_halted: got %0d expected 514", halted_cnt - h0);
    else pass_cnt++;
    check_cnt++;
    if (halted1_cnt - h1 != 513) $display("FAIL odd_halted_noalign: got %0d expected 513", halted1_cnt - h1);
    else pass_cnt++;
    check_cnt++;
    if (gap_cnt - g0 != 2) $display("FAIL odd_gap_cycles: got %0d expected 2", gap_cnt - g0);
    else pass_cnt++;
    exp_xor = 8'h00;
    for (int i = 0; i < 256; i++) exp_xor = exp_xor ^ mem_arr[{pg, 8'(i)}];
    check_cnt++;
    if (wr1_cnt - w1b != 256 || (wr1_xor ^ x0) !== exp_xor)
      $display("FAIL odd_noalign_stream: writes=%0d xor=%h expected 256/%h", wr1_cnt - w1b, wr1_xor ^ x0, exp_xor);
    else pass_cnt++;
    check_cnt++;
    if (rd_q.size() - rb != 256 || wr_q.size() - wb != 256)
      $display("FAIL odd_counts: reads=%0d writes=%0d expected 256/256", rd_q.size() - rb, wr_q.size() - wb);
    else begin
      pass_cnt++;
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (rd_q[rb + i] !== {pg, 8'(i)} || wr_q[wb + i] !== mem_arr[{pg, 8'(i)}]) bad++;
      check_cnt++;
      if (bad != 0) $display("FAIL odd_stream: %0d mismatched entries of 256 expected 0", bad);
      else pass_cnt++;
    end
    $display("test_dma_odd page=%h done", pg);
  endtask

  task automatic test_page_ff();
    int rb, wb, zero_hits, bad;
    bit to;
    rb = rd_q.size(); wb = wr_q.size();
    run_dma(8'hFF, 1'($urandom), 1'b0, to);
    check_cnt++;
    if (to) $display("FAIL ff_timeout: busy=%b expected 0 within budget", busy);
    else pass_cnt++;
    check_cnt++;
    if (rd_q.size() - rb != 256 || wr_q.size() - wb != 256)
      $display("FAIL ff_counts: reads=%0d writes=%0d expected 256/256", rd_q.size() - rb, wr_q.size() - wb);
    else begin
      pass_cnt++;
      zero_hits = 0; bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (rd_q[rb + i][15:8] !== 8'hFF) zero_hits++;
        if (wr_q[wb + i] !== mem_arr[{8'hFF, 8'(i)}]) bad++;
      end
      check_cnt++;
      if (rd_q[rb + 255] !== 16'hFFFF) $display("FAIL ff_last_read: got %h expected ffff", rd_q[rb + 255]);
      else pass_cnt++;
      check_cnt++;
      if (zero_hits != 0) $display("FAIL ff_wrap: %0d reads outside page ff expected 0", zero_hits);
      else pass_cnt++;
      check_cnt++;
      if (bad != 0) $display("FAIL ff_data: %0d wrong bytes expected 0", bad);
      else pass_cnt++;
    end
    @(posedge clock); #1;
    check_cnt++;
    if (busy !== 1'b0 || cpu_ready !== 1'b1) $display("FAIL ff_idle_after: busy=%b ready=%b expected 0/1", busy, cpu_ready);
    else pass_cnt++;
    $display("test_page_ff done");
  endtask

  task automatic test_retrigger();
    int h0, rb, wb, bad;
    bit to;
    h0 = halted_cnt; rb = rd_q.size(); wb = wr_q.size();
    run_dma(8'h02, 1'b0, 1'b1, to);
    check_cnt++;
    if (to) $display("FAIL retrig_timeout: busy=%b expected 0 within budget", busy);
    else pass_cnt++;
    check_cnt++;
    if (halted_cnt - h0 != 513) $display("FAIL retrig_halted: got %0d expected 513", halted_cnt - h0);
    else pass_cnt++;
    check_cnt++;
    if (rd_q.size() - rb != 256 || wr_q.size() - wb != 256)
      $display("FAIL retrig_counts: reads=%0d writes=%0d expected 256/256", rd_q.size() - rb, wr_q.size() - wb);
    else begin
      pass_cnt++;
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (rd_q[rb + i] !== 16'h0200 + 16'(i) || wr_q[wb + i] !== (8'(i) ^ 8'hA5)) bad++;
      check_cnt++;
      if (bad != 0) $display("FAIL retrig_stream: %0d wrong entries expected 0 (page 02)", bad);
      else pass_cnt++;
    end
    @(posedge clock); #1;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL retrig_no_requeue: busy=%b expected 0", busy);
    else pass_cnt++;
    $display("test_retrigger done");
  endtask

  task automatic test_mid_reset();
    int oam0, rb;
    bit found;
    @(posedge clock); #1;
    cpu_address = DMA_PORT; cpu_out = 8'h02; cpu_we = 1'b1; cpu_rd = 1'b0;
    @(posedge clock); #1;
    cpu_we = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (mem_rd && mem_address == 16'h0240) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    check_cnt++;
    if (!found) $display("FAIL midreset_reach_idx40: addr=%h expected 0240 read", mem_address);
    else pass_cnt++;
    reset = 1'b1;
    cpu_address = 16'h0777; cpu_out = 8'h3C; cpu_we = 1'b1; cpu_rd = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_cnt++;
    if (busy !== 1'b0 || cpu_ready !== 1'b1)
      $display("FAIL midreset_idle: busy=%b ready=%b expected 0/1", busy, cpu_ready);
    else pass_cnt++;
    check_cnt++;
    if (mem_address !== 16'h0777 || mem_out !== 8'h3C || mem_we !== 1'b1 || mem_rd !== 1'b0)
      $display("FAIL midreset_mirror: mem=%h/%h/%b/%b expected 0777/3c/0/1", mem_address, mem_out, mem_rd, mem_we);
    else pass_cnt++;
    cpu_we = 1'b0;
    oam0 = oam_cnt; rb = rd_q.size();
    repeat (20) @(posedge clock);
    #1;
    check_cnt++;
    if (oam_cnt != oam0 || rd_q.size() != rb || busy !== 1'b0)
      $display("FAIL midreset_abandoned: oam_writes=%0d reads=%0d busy=%b expected 0/0/0",
               oam_cnt - oam0, rd_q.size() - rb, busy);
    else pass_cnt++;
    $display("test_mid_reset done");
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem_arr[a] = 8'($urandom);
    test_reset();
    test_passthrough();
    test_dma_even();
    test_dma_odd();
    test_page_ff();
    test_retrigger();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/nes_oam_dma.md
Name: nes_oam_dma

Overview:
Bus owner and sequencer for the single CPU memory bus. In normal operation it passes the 6502 core's address, data, rd and we straight through to memory. When the CPU writes to the DMA trigger port, the block halts the CPU. It then copies one 256-byte page to the OAM data port as alternating read/write cycles, and hands the bus back to the CPU when done. It sits between the CPU core and the memory/IO decode.

Parameters:
DMA_PORT, 16'h4014, CPU write address that triggers a DMA; the written byte is the source page.
OAM_PORT, 16'h2004, destination address for every DMA write cycle.
ALIGN_EN, 1, when 1 an extra alignment cycle is inserted if the halt cycle falls on an odd cycle.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
cpu_address  in  16  CPU address
cpu_out  in  8  CPU write data
cpu_rd  in  1  CPU read strobe
cpu_we  in  1  CPU write strobe
cpu_ready  out  1  1 = CPU may advance; 0 = CPU must hold its current cycle
mem_address  out  16  address to memory/IO
mem_out  out  8  write data to memory/IO
mem_rd  out  1  read strobe to memory
mem_we  out  1  write strobe to memory
mem_data  in  8  read data from memory; valid in the same cycle as mem_rd
busy  out  1  1 while state != IDLE

Behaviour:
- State machine: IDLE, HALT, ALIGN, READ, WRITE. Internal registers:
  - page[7:0]
  - idx[7:0]
  - latch[7:0]
  - odd (cycle parity flop, toggles every clock, 0 after reset)
- Reset state:
  - state=IDLE; page=idx=latch=0; odd=0.
  - Hence cpu_ready=1, busy=0, and mem_* mirror the cpu_* inputs.
- IDLE:
  - mem_address=cpu_address, mem_out=cpu_out, mem_rd=cpu_rd, mem_we=cpu_we, cpu_ready=1.
  - If cpu_we=1 and cpu_address==DMA_PORT: page<=cpu_out, idx<=0, state<=HALT.
  - The trigger write itself still passes through to memory in that cycle.
- HALT (1 cycle):
  - cpu_ready=0, mem_rd=mem_we=0, mem_address=cpu_address, mem_out=cpu_out.
  - Next state is ALIGN if ALIGN_EN=1 and odd=1; otherwise READ.
- ALIGN (1 cycle): same outputs as HALT; next state READ.
- READ:
  - cpu_ready=0, mem_address={page,idx}, mem_rd=1, mem_we=0.
  - latch<=mem_data at the end of the cycle; next state WRITE.
- WRITE:
  - cpu_ready=0, mem_address=OAM_PORT, mem_out=latch, mem_we=1, mem_rd=0.
  - idx<=idx+1 (8-bit, wraps).
  - If idx==8'hFF, next state is IDLE; otherwise READ.
- Timing:
  - Total halted cycles = 1 + align(0/1) + 512, i.e. 513 or 514.
  - cpu_ready returns to 1 in the first cycle after the final WRITE.
  - The source address never carries into the page byte: the copy covers {page,00}..{page,FF} exactly.
- cpu_ready, busy and all mem_* outputs are combinational from state and registers. There is no registered output latency; memory sees the DMA address in the same cycle as the state.
- cpu_* inputs are ignored while busy=1, including a further write to DMA_PORT; there is no re-trigger or queueing.
- Reset asserted mid-DMA: the next state is IDLE, idx=0, cpu_ready=1. The partial copy is abandoned and not resumed.
- The trigger is detected only on cpu_we. cpu_rd of DMA_PORT has no effect.

Test Plan:
- Passthrough: in IDLE, drive cpu_address=16'h1234, cpu_out=8'h5A, cpu_we=1 -> same cycle mem_address=16'h1234, mem_out=8'h5A, mem_we=1, cpu_ready=1, busy=0.
- Even-aligned DMA:
  - Preload 16'h0200+i = i^8'hA5; write 8'h02 to 16'h4014 while the HALT cycle falls on odd=0.
  - Expect exactly 513 cycles with cpu_ready=0.
  - Expect 256 writes to 16'h2004 with data 8'hA5, 8'hA4, ... in index order.
  - Reads must hit addresses 16'h0200..16'h02FF only.
- Odd-aligned DMA: same trigger issued one cycle later so the HALT cycle has odd=1 -> exactly 514 halted cycles, one ALIGN cycle with mem_rd=mem_we=0; data sequence identical. With ALIGN_EN=0 -> 513.
- Page FF wrap: trigger with 8'hFF -> last read at 16'hFFFF, next state IDLE; no access to 16'h0000 and no 257th write.
- Ignored re-trigger: during DMA, drive cpu_we=1, cpu_address=16'h4014, cpu_out=8'h07 -> no effect; page stays 8'h02, and the transfer completes unchanged.
- Mid-DMA reset: assert reset for 1 cycle at idx=8'h40 -> the next cycle has state IDLE, cpu_ready=1, busy=0, mem_* mirror cpu_*; no further writes to 16'h2004.
